// File: rtl/hazard_ctrl.sv
// Load-use / redirect / memory-stall hazard controller for the 5-stage pipeline.
// Optional saturating hazard statistics are enabled with `define HAZARD_STATS_EN.
module hazard_ctrl #(
  parameter int unsigned LOAD_LAT     = 1,
  parameter int unsigned FLUSH_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] IFID_Rs,
  input  logic [4:0] IFID_Rt,
  input  logic       IFID_UsesRt,
  input  logic       IDEX_MemRead,
  input  logic [4:0] IDEX_Rt,
  input  logic       EX_Redirect,
  input  logic       Mem_Busy,
  output logic       PC_WriteEn,
  output logic       IFID_WriteEn,
  output logic       IFID_Flush,
  output logic       IDEX_WriteEn,
  output logic       IDEX_Flush
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0] Stall_Cnt,
  output logic [31:0] Flush_Cnt
`endif
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    FLUSH    = 2'd2
  } state_t;

  localparam logic [2:0] LU_RELOAD = 3'(LOAD_LAT - 1);
  localparam logic [2:0] FL_RELOAD = 3'(FLUSH_CYCLES - 1);

  state_t     state, state_nxt;
  logic [2:0] cnt, cnt_nxt;
  logic       lu;

  assign lu = IDEX_MemRead && (IDEX_Rt != 5'd0) &&
              ((IDEX_Rt == IFID_Rs) || (IFID_UsesRt && (IDEX_Rt == IFID_Rt)));

  // Outputs are gated by rst_n so they drop to zero asynchronously during reset.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    PC_WriteEn   = 1'b0;
    IFID_WriteEn = 1'b0;
    IFID_Flush   = 1'b0;
    IDEX_WriteEn = 1'b0;
    IDEX_Flush   = 1'b0;
    if (!rst_n || Mem_Busy) begin
      state_nxt = state;
    end else if (EX_Redirect) begin
      PC_WriteEn   = 1'b1;
      IFID_WriteEn = 1'b1;
      IFID_Flush   = 1'b1;
      IDEX_WriteEn = 1'b1;
      IDEX_Flush   = 1'b1;
      if (FLUSH_CYCLES > 1) begin
        state_nxt = FLUSH;
        cnt_nxt   = FL_RELOAD;
      end else begin
        state_nxt = RUN;
        cnt_nxt   = '0;
      end
    end else if (state == LU_STALL || (state == RUN && lu)) begin
      IDEX_WriteEn = 1'b1;
      IDEX_Flush   = 1'b1;
      if (state == LU_STALL) begin
        if (cnt == 3'd1) begin
          state_nxt = RUN;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt - 3'd1;
        end
      end else if (LOAD_LAT > 1) begin
        state_nxt = LU_STALL;
        cnt_nxt   = LU_RELOAD;
      end
    end else if (state == FLUSH) begin
      PC_WriteEn   = 1'b1;
      IFID_WriteEn = 1'b1;
      IFID_Flush   = 1'b1;
      IDEX_WriteEn = 1'b1;
      if (cnt == 3'd1) begin
        state_nxt = RUN;
        cnt_nxt   = '0;
      end else begin
        cnt_nxt = cnt - 3'd1;
      end
    end else begin
      PC_WriteEn   = 1'b1;
      IFID_WriteEn = 1'b1;
      IDEX_WriteEn = 1'b1;
      state_nxt    = RUN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

`ifdef HAZARD_STATS_EN
  logic stall_cyc, redirect_acc;

  // PC_WriteEn is only low outside busy/reset because of a load-use stall.
  assign stall_cyc    = !PC_WriteEn && !Mem_Busy;
  assign redirect_acc = EX_Redirect && !Mem_Busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Stall_Cnt <= '0;
      Flush_Cnt <= '0;
    end else begin
      if (stall_cyc && Stall_Cnt != '1)
        Stall_Cnt <= Stall_Cnt + 32'd1;
      if (redirect_acc && Flush_Cnt != '1)
        Flush_Cnt <= Flush_Cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: two instances (LOAD_LAT=1/FLUSH_CYCLES=2 and
// LOAD_LAT=3/FLUSH_CYCLES=3) share stimulus; outputs packed {PC_WE,IFID_WE,IFID_FL,IDEX_WE,IDEX_FL}.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] rs, rt, idex_rt;
  logic       uses_rt, mem_read, redirect, busy;

  logic pc_we_a, ifid_we_a, ifid_fl_a, idex_we_a, idex_fl_a;
  logic pc_we_b, ifid_we_b, ifid_fl_b, idex_we_b, idex_fl_b;
  logic [4:0] o_a, o_b;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  localparam logic [4:0] ZERO  = 5'b00000;
  localparam logic [4:0] NORM  = 5'b11010;
  localparam logic [4:0] STALL = 5'b00011;
  localparam logic [4:0] REDIR = 5'b11111;
  localparam logic [4:0] FLSH  = 5'b11110;

`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cnt_a, flush_cnt_a, stall_cnt_b, flush_cnt_b;
`endif

  always #5 clk = ~clk;

  hazard_ctrl #(.LOAD_LAT(1), .FLUSH_CYCLES(2)) u_a (
    .clk(clk), .rst_n(rst_n),
    .IFID_Rs(rs), .IFID_Rt(rt), .IFID_UsesRt(uses_rt),
    .IDEX_MemRead(mem_read), .IDEX_Rt(idex_rt),
    .EX_Redirect(redirect), .Mem_Busy(busy),
    .PC_WriteEn(pc_we_a), .IFID_WriteEn(ifid_we_a), .IFID_Flush(ifid_fl_a),
    .IDEX_WriteEn(idex_we_a), .IDEX_Flush(idex_fl_a)
`ifdef HAZARD_STATS_EN
    , .Stall_Cnt(stall_cnt_a), .Flush_Cnt(flush_cnt_a)
`endif
  );

  hazard_ctrl #(.LOAD_LAT(3), .FLUSH_CYCLES(3)) u_b (
    .clk(clk), .rst_n(rst_n),
    .IFID_Rs(rs), .IFID_Rt(rt), .IFID_UsesRt(uses_rt),
    .IDEX_MemRead(mem_read), .IDEX_Rt(idex_rt),
    .EX_Redirect(redirect), .Mem_Busy(busy),
    .PC_WriteEn(pc_we_b), .IFID_WriteEn(ifid_we_b), .IFID_Flush(ifid_fl_b),
    .IDEX_WriteEn(idex_we_b), .IDEX_Flush(idex_fl_b)
`ifdef HAZARD_STATS_EN
    , .Stall_Cnt(stall_cnt_b), .Flush_Cnt(flush_cnt_b)
`endif
  );

  assign o_a = {pc_we_a, ifid_we_a, ifid_fl_a, idex_we_a, idex_fl_a};
  assign o_b = {pc_we_b, ifid_we_b, ifid_fl_b, idex_we_b, idex_fl_b};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_in(input logic mr, input logic [4:0] xrt, input logic [4:0] s,
                        input logic [4:0] t, input logic ur, input logic rd, input logic bz);
    mem_read = mr; idex_rt = xrt; rs = s; rt = t; uses_rt = ur; redirect = rd; busy = bz;
  endtask

  task automatic check_both(input string tag, input logic [4:0] ea, input logic [4:0] eb);
    check({tag, "/a"}, 32'(o_a), 32'(ea));
    check({tag, "/b"}, 32'(o_b), 32'(eb));
  endtask

  // Inputs are applied #1 after posedge; outputs are sampled on the following negedge.
  task automatic cyc(input string tag, input logic [4:0] ea, input logic [4:0] eb);
    @(negedge clk);
    check_both(tag, ea, eb);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0);
    #3;
    check_both("reset_async", ZERO, ZERO);
    set_in(1, 5'd8, 5'd8, 0, 0, 1, 0);
    #1;
    check_both("reset_inputs_active", ZERO, ZERO);
    set_in(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Baseline: no hazards
    for (int i = 0; i < 10; i++) cyc("baseline", NORM, NORM);

    // Load-use on rs
    set_in(1, 5'd8, 5'd8, 5'd3, 1, 0, 0);
    cyc("lu_rs_c0", STALL, STALL);
    set_in(0, 0, 0, 0, 0, 0, 0);
    cyc("lu_rs_c1", NORM, STALL);
    cyc("lu_rs_c2", NORM, STALL);
    cyc("lu_rs_c3", NORM, NORM);

    // Zero register and unused rt
    set_in(1, 5'd0, 5'd0, 5'd0, 1, 0, 0);
    cyc("lu_zero_reg", NORM, NORM);
    set_in(1, 5'd9, 5'd1, 5'd9, 0, 0, 0);
    cyc("lu_rt_unused", NORM, NORM);
    set_in(1, 5'd9, 5'd1, 5'd9, 1, 0, 0);
    cyc("lu_rt_used", STALL, STALL);
    set_in(0, 0, 0, 0, 0, 0, 0);
    cyc("lu_rt_c1", NORM, STALL);
    cyc("lu_rt_c2", NORM, STALL);
    cyc("lu_rt_c3", NORM, NORM);

    // Redirect with multi-cycle flush
    set_in(0, 0, 0, 0, 0, 1, 0);
    cyc("redir_c0", REDIR, REDIR);
    set_in(0, 0, 0, 0, 0, 0, 0);
    cyc("redir_c1", FLSH, FLSH);
    cyc("redir_c2", NORM, FLSH);
    cyc("redir_c3", NORM, NORM);

    // Second redirect while flushing reloads the count
    set_in(0, 0, 0, 0, 0, 1, 0);
    cyc("rerdir_c0", REDIR, REDIR);
    cyc("rerdir_c1", REDIR, REDIR);
    set_in(0, 0, 0, 0, 0, 0, 0);
    cyc("rerdir_c2", FLSH, FLSH);
    cyc("rerdir_c3", NORM, FLSH);
    cyc("rerdir_c4", NORM, NORM);

    // Load-use and redirect together: redirect wins
    set_in(1, 5'd8, 5'd8, 0, 0, 1, 0);
    cyc("lu_redir_c0", REDIR, REDIR);
    set_in(0, 0, 0, 0, 0, 0, 0);
    cyc("lu_redir_c1", FLSH, FLSH);
    cyc("lu_redir_c2", NORM, FLSH);
    cyc("lu_redir_c3", NORM, NORM);

    // Redirect aborts an in-progress load-use stall
    set_in(1, 5'd8, 5'd8, 0, 0, 0, 0);
    cyc("abort_c0", STALL, STALL);
    set_in(0, 0, 0, 0, 0, 1, 0);
    cyc("abort_c1", REDIR, REDIR);
    set_in(0, 0, 0, 0, 0, 0, 0);
    cyc("abort_c2", FLSH, FLSH);
    cyc("abort_c3", NORM, FLSH);
    cyc("abort_c4", NORM, NORM);

    // Mem_Busy freezes an in-progress stall
    set_in(1, 5'd8, 5'd8, 0, 0, 0, 0);
    cyc("busy_lu_c0", STALL, STALL);
    set_in(0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) cyc("busy_freeze", ZERO, ZERO);
    set_in(0, 0, 0, 0, 0, 0, 0);
    cyc("busy_resume_c0", NORM, STALL);
    cyc("busy_resume_c1", NORM, STALL);
    cyc("busy_resume_c2", NORM, NORM);

    // Redirect and hazard ignored while busy
    set_in(1, 5'd8, 5'd8, 0, 0, 1, 1);
    cyc("busy_redir", ZERO, ZERO);
    set_in(0, 0, 0, 0, 0, 0, 0);
    cyc("busy_redir_after", NORM, NORM);

    // Reset mid-flush
    set_in(0, 0, 0, 0, 0, 1, 0);
    cyc("rst_redir", REDIR, REDIR);
    set_in(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check_both("rst_pre", FLSH, FLSH);
    #2;
    rst_n = 1'b0;
    #1;
    check_both("rst_mid_flush", ZERO, ZERO);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check_both("rst_release", NORM, NORM);
    @(posedge clk);
    #1;
    cyc("rst_no_stale", NORM, NORM);

    // Two stalls and one redirect after reset
    for (int k = 0; k < 2; k++) begin
      set_in(1, 5'd8, 5'd8, 0, 0, 0, 0);
      cyc("stat_lu_c0", STALL, STALL);
      set_in(0, 0, 0, 0, 0, 0, 0);
      cyc("stat_lu_c1", NORM, STALL);
      cyc("stat_lu_c2", NORM, STALL);
      cyc("stat_lu_c3", NORM, NORM);
    end
    set_in(0, 0, 0, 0, 0, 1, 0);
    cyc("stat_redir_c0", REDIR, REDIR);
    set_in(0, 0, 0, 0, 0, 0, 0);
    cyc("stat_redir_c1", FLSH, FLSH);
    cyc("stat_redir_c2", NORM, FLSH);
    cyc("stat_redir_c3", NORM, NORM);

`ifdef HAZARD_STATS_EN
    check("stall_cnt/a", stall_cnt_a, 32'd2);
    check("flush_cnt/a", flush_cnt_a, 32'd1);
    check("stall_cnt/b", stall_cnt_b, 32'd6);
    check("flush_cnt/b", flush_cnt_b, 32'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
